// File: rtl/branch_pc_ctrl.sv
// Fetch-side PC controller: owns the F-stage PC, resolves D-stage control
// transfers into a redirect, tracks the MIPS delay slot, produces the link
// address and keeps branch/taken counters for performance debug.
//
// Handshake note: there is no valid/ready pair here. D presents an
// instruction with d_valid; it is consumed on a rising edge where
// d_valid=1 and stall=0. While stall=1 nothing is consumed and all state
// holds, and the decision is re-evaluated from the live inputs each cycle.
module branch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             d_valid,
   input  logic [2:0]       br_type,
   input  logic [1:0]       cmp,
   input  logic [31:0]      d_pc,
   input  logic [15:0]      imm16,
   input  logic [25:0]      instr_index,
   input  logic [31:0]      jr_target,
   output logic [31:0]      pc,
   output logic             link_en,
   output logic [31:0]      link_addr,
   output logic             in_slot,
   output logic             slot_err,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   localparam logic [2:0] BR_NONE   = 3'd0;
   localparam logic [2:0] BR_BEQ    = 3'd1;
   localparam logic [2:0] BR_BNE    = 3'd2;
   localparam logic [2:0] BR_BGEZAL = 3'd3;
   localparam logic [2:0] BR_J      = 3'd4;
   localparam logic [2:0] BR_JAL    = 3'd5;
   localparam logic [2:0] BR_JR     = 3'd6;

   // SEQ: D holds an ordinary instruction. SLOT: D holds a delay slot.
   typedef enum logic [0:0] {
      SEQ  = 1'b0,
      SLOT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             slot_err_q, slot_err_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   logic        is_br;
   logic        taken;
   logic        advance;
   logic        redirect;
   logic [31:0] d_pc_plus4;
   logic [31:0] br_offset;
   logic [31:0] target;

   // Decode the transfer class, its taken decision and its target.
   always_comb begin
      is_br      = 1'b0;
      taken      = 1'b0;
      d_pc_plus4 = d_pc + 32'd4;
      br_offset  = {{14{imm16[15]}}, imm16, 2'b00};
      target     = d_pc_plus4 + br_offset;
      case (br_type)
         BR_BEQ: begin
            is_br = 1'b1;
            taken = (cmp == 2'd1);
         end
         BR_BNE: begin
            is_br = 1'b1;
            taken = (cmp != 2'd1);
         end
         BR_BGEZAL: begin
            is_br = 1'b1;
            taken = (cmp == 2'd2);
         end
         BR_J, BR_JAL: begin
            is_br  = 1'b1;
            taken  = 1'b1;
            target = {d_pc_plus4[31:28], instr_index, 2'b00};
         end
         BR_JR: begin
            is_br  = 1'b1;
            taken  = 1'b1;
            target = jr_target;
         end
         default: begin
            is_br = 1'b0;
            taken = 1'b0;
         end
      endcase
   end

   // Redirect and link only for instructions outside a delay slot.
   always_comb begin
      advance   = d_valid & ~stall;
      redirect  = d_valid & is_br & taken & (state_q == SEQ);
      link_en   = d_valid & (state_q == SEQ) &
                  ((br_type == BR_JAL) | (br_type == BR_BGEZAL));
      link_addr = d_pc + 32'd8;
   end

   // Next PC, FSM transition, sticky slot error and counters.
   always_comb begin
      pc_d        = pc_q;
      state_d     = state_q;
      slot_err_d  = slot_err_q;
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;

      if (!stall) begin
         pc_d = redirect ? target : (pc_q + 32'd4);
      end

      case (state_q)
         SEQ: begin
            if (advance && is_br) begin
               state_d  = SLOT;
               br_cnt_d = br_cnt_q + 1'b1;
               if (taken) begin
                  taken_cnt_d = taken_cnt_q + 1'b1;
               end
            end
         end
         SLOT: begin
            if (advance) begin
               state_d = SEQ;
               if (is_br) begin
                  slot_err_d = 1'b1;
               end
            end
         end
         default: state_d = SEQ;
      endcase
   end

   // State registers; synchronous active-low reset dominates everything.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q        <= RESET_PC;
         state_q     <= SEQ;
         slot_err_q  <= 1'b0;
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         state_q     <= state_d;
         slot_err_q  <= slot_err_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign pc        = pc_q;
   assign in_slot   = (state_q == SLOT);
   assign slot_err  = slot_err_q;
   assign br_cnt    = br_cnt_q;
   assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed bench for branch_pc_ctrl. Counters are instantiated at 4 bits so
// the wrap case is reachable quickly.
module tb_branch_pc_ctrl;

   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             stall;
   logic             d_valid;
   logic [2:0]       br_type;
   logic [1:0]       cmp;
   logic [31:0]      d_pc;
   logic [15:0]      imm16;
   logic [25:0]      instr_index;
   logic [31:0]      jr_target;
   logic [31:0]      pc;
   logic             link_en;
   logic [31:0]      link_addr;
   logic             in_slot;
   logic             slot_err;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] taken_cnt;

   int checks;
   int failures;

   branch_pc_ctrl #(
      .RESET_PC (32'h0000_3000),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .d_valid     (d_valid),
      .br_type     (br_type),
      .cmp         (cmp),
      .d_pc        (d_pc),
      .imm16       (imm16),
      .instr_index (instr_index),
      .jr_target   (jr_target),
      .pc          (pc),
      .link_en     (link_en),
      .link_addr   (link_addr),
      .in_slot     (in_slot),
      .slot_err    (slot_err),
      .br_cnt      (br_cnt),
      .taken_cnt   (taken_cnt)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall       = 1'b0;
      d_valid     = 1'b0;
      br_type     = 3'd0;
      cmp         = 2'd0;
      d_pc        = 32'h0;
      imm16       = 16'h0;
      instr_index = 26'h0;
      jr_target   = 32'h0;
   endtask

   // Two reset cycles, then release; pc holds RESET_PC until the next edge.
   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (pc !== 32'h0000_3000) begin
         failures++;
         $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0000_3000);
      end
      checks++;
      if (in_slot !== 1'b0 || slot_err !== 1'b0 || br_cnt !== 4'd0 || taken_cnt !== 4'd0) begin
         failures++;
         $display("FAIL reset_state got in_slot=%b slot_err=%b br=%0d tk=%0d exp 0 0 0 0",
                  in_slot, slot_err, br_cnt, taken_cnt);
      end
      tick();
      checks++;
      if (pc !== 32'h0000_3004) begin
         failures++;
         $display("FAIL seq_pc1 got=%h exp=%h", pc, 32'h0000_3004);
      end
      tick();
      checks++;
      if (pc !== 32'h0000_3008) begin
         failures++;
         $display("FAIL seq_pc2 got=%h exp=%h", pc, 32'h0000_3008);
      end
   endtask

   task automatic test_beq_taken();
      do_reset();
      d_valid = 1'b1; d_pc = 32'h0000_3010; br_type = 3'd1; cmp = 2'd1; imm16 = 16'hFFFC;
      #1;
      checks++;
      if (link_en !== 1'b0 || link_addr !== 32'h0000_3018) begin
         failures++;
         $display("FAIL beq_link got en=%b addr=%h exp en=0 addr=%h", link_en, link_addr, 32'h0000_3018);
      end
      tick();
      checks++;
      if (pc !== 32'h0000_3004 || in_slot !== 1'b1) begin
         failures++;
         $display("FAIL beq_redirect got pc=%h slot=%b exp pc=%h slot=1", pc, in_slot, 32'h0000_3004);
      end
      checks++;
      if (br_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
         failures++;
         $display("FAIL beq_cnt got br=%0d tk=%0d exp 1 1", br_cnt, taken_cnt);
      end
      br_type = 3'd0; d_pc = 32'h0000_3014;
      tick();
      checks++;
      if (pc !== 32'h0000_3008 || in_slot !== 1'b0) begin
         failures++;
         $display("FAIL beq_after_slot got pc=%h slot=%b exp pc=%h slot=0", pc, in_slot, 32'h0000_3008);
      end
   endtask

   task automatic test_bne_not_taken();
      do_reset();
      d_valid = 1'b1; d_pc = 32'h0000_3000; br_type = 3'd2; cmp = 2'd1; imm16 = 16'h0040;
      tick();
      checks++;
      if (pc !== 32'h0000_3004 || br_cnt !== 4'd1 || taken_cnt !== 4'd0 || in_slot !== 1'b1) begin
         failures++;
         $display("FAIL bne_nt got pc=%h br=%0d tk=%0d slot=%b exp pc=%h 1 0 1",
                  pc, br_cnt, taken_cnt, in_slot, 32'h0000_3004);
      end
   endtask

   task automatic test_bgezal_stall();
      do_reset();
      d_valid = 1'b1; d_pc = 32'h0000_3020; br_type = 3'd3; cmp = 2'd0; imm16 = 16'h0010;
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (link_en !== 1'b1 || link_addr !== 32'h0000_3028) begin
            failures++;
            $display("FAIL bgezal_link_stall got en=%b addr=%h exp en=1 addr=%h", link_en, link_addr, 32'h0000_3028);
         end
         tick();
         checks++;
         if (pc !== 32'h0000_3000 || br_cnt !== 4'd0 || in_slot !== 1'b0) begin
            failures++;
            $display("FAIL bgezal_hold got pc=%h br=%0d slot=%b exp pc=%h 0 0", pc, br_cnt, in_slot, 32'h0000_3000);
         end
      end
      stall = 1'b0; cmp = 2'd2;
      #1;
      checks++;
      if (link_en !== 1'b1 || link_addr !== 32'h0000_3028) begin
         failures++;
         $display("FAIL bgezal_link got en=%b addr=%h exp en=1 addr=%h", link_en, link_addr, 32'h0000_3028);
      end
      tick();
      checks++;
      if (pc !== 32'h0000_3064 || br_cnt !== 4'd1 || taken_cnt !== 4'd1 || in_slot !== 1'b1) begin
         failures++;
         $display("FAIL bgezal_redirect got pc=%h br=%0d tk=%0d slot=%b exp pc=%h 1 1 1",
                  pc, br_cnt, taken_cnt, in_slot, 32'h0000_3064);
      end
   endtask

   task automatic test_jr_forward();
      do_reset();
      d_valid = 1'b1; br_type = 3'd6; d_pc = 32'h0000_3040; jr_target = 32'h0000_1111; stall = 1'b1;
      tick();
      tick();
      checks++;
      if (pc !== 32'h0000_3000) begin
         failures++;
         $display("FAIL jr_hold got=%h exp=%h", pc, 32'h0000_3000);
      end
      stall = 1'b0; jr_target = 32'h0000_3400;
      #1;
      checks++;
      if (link_en !== 1'b0) begin
         failures++;
         $display("FAIL jr_link got=%b exp=0", link_en);
      end
      tick();
      checks++;
      if (pc !== 32'h0000_3400) begin
         failures++;
         $display("FAIL jr_redirect got=%h exp=%h", pc, 32'h0000_3400);
      end
   endtask

   task automatic test_jal_and_wrap();
      do_reset();
      d_valid = 1'b1; br_type = 3'd5; d_pc = 32'hF000_0000; instr_index = 26'h000_0123;
      #1;
      checks++;
      if (link_en !== 1'b1 || link_addr !== 32'hF000_0008) begin
         failures++;
         $display("FAIL jal_link got en=%b addr=%h exp en=1 addr=%h", link_en, link_addr, 32'hF000_0008);
      end
      tick();
      checks++;
      if (pc !== 32'hF000_048C) begin
         failures++;
         $display("FAIL jal_target got=%h exp=%h", pc, 32'hF000_048C);
      end
      // Branch target arithmetic wraps at 2^32.
      do_reset();
      d_valid = 1'b1; br_type = 3'd1; cmp = 2'd1; d_pc = 32'hFFFF_FFF8; imm16 = 16'h0001;
      tick();
      checks++;
      if (pc !== 32'h0000_0000) begin
         failures++;
         $display("FAIL beq_wrap got=%h exp=%h", pc, 32'h0000_0000);
      end
   endtask

   task automatic test_slot_branch();
      do_reset();
      d_valid = 1'b1; br_type = 3'd4; d_pc = 32'h0000_3000; instr_index = 26'h000_0C40;
      tick();
      checks++;
      if (pc !== 32'h0000_3100 || in_slot !== 1'b1) begin
         failures++;
         $display("FAIL j_redirect got pc=%h slot=%b exp pc=%h slot=1", pc, in_slot, 32'h0000_3100);
      end
      // A bubble keeps the slot pending.
      d_valid = 1'b0; br_type = 3'd0;
      tick();
      checks++;
      if (pc !== 32'h0000_3104 || in_slot !== 1'b1) begin
         failures++;
         $display("FAIL slot_bubble got pc=%h slot=%b exp pc=%h slot=1", pc, in_slot, 32'h0000_3104);
      end
      // Taken beq sitting in the delay slot.
      d_valid = 1'b1; br_type = 3'd1; cmp = 2'd1; d_pc = 32'h0000_3004; imm16 = 16'h0010;
      #1;
      checks++;
      if (link_en !== 1'b0) begin
         failures++;
         $display("FAIL slot_link got=%b exp=0", link_en);
      end
      tick();
      checks++;
      if (pc !== 32'h0000_3108 || slot_err !== 1'b1 || in_slot !== 1'b0) begin
         failures++;
         $display("FAIL slot_branch got pc=%h err=%b slot=%b exp pc=%h err=1 slot=0",
                  pc, slot_err, in_slot, 32'h0000_3108);
      end
      checks++;
      if (br_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
         failures++;
         $display("FAIL slot_cnt got br=%0d tk=%0d exp 1 1", br_cnt, taken_cnt);
      end
      br_type = 3'd0; d_pc = 32'h0000_3100;
      tick();
      checks++;
      if (slot_err !== 1'b1) begin
         failures++;
         $display("FAIL slot_err_sticky got=%b exp=1", slot_err);
      end
   endtask

   task automatic test_reset_mid_slot();
      do_reset();
      d_valid = 1'b1; br_type = 3'd4; d_pc = 32'h0000_3000; instr_index = 26'h000_0C40;
      tick();
      // Slot branch raises slot_err, then reset lands while the FSM is in SLOT again.
      br_type = 3'd4; d_pc = 32'h0000_3004;
      tick();
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (pc !== 32'h0000_3000 || in_slot !== 1'b0 || slot_err !== 1'b0 || br_cnt !== 4'd0) begin
         failures++;
         $display("FAIL reset_mid_slot got pc=%h slot=%b err=%b br=%0d exp pc=%h 0 0 0",
                  pc, in_slot, slot_err, br_cnt, 32'h0000_3000);
      end
      reset = 1'b1;
      idle_inputs();
      tick();
      checks++;
      if (pc !== 32'h0000_3004) begin
         failures++;
         $display("FAIL post_reset_seq got=%h exp=%h", pc, 32'h0000_3004);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         d_valid = 1'b1; br_type = 3'd4; d_pc = 32'h0000_3000; instr_index = 26'h000_0C40;
         tick();
         br_type = 3'd0; d_pc = 32'h0000_3004;
         tick();
      end
      checks++;
      if (br_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
         failures++;
         $display("FAIL cnt_wrap got br=%0d tk=%0d exp 1 1", br_cnt, taken_cnt);
      end
      checks++;
      if (pc !== 32'h0000_3104 || slot_err !== 1'b0) begin
         failures++;
         $display("FAIL cnt_wrap_pc got pc=%h err=%b exp pc=%h err=0", pc, slot_err, 32'h0000_3104);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      idle_inputs();
      test_reset();
      test_beq_taken();
      test_bne_not_taken();
      test_bgezal_stall();
      test_jr_forward();
      test_jal_and_wrap();
      test_slot_branch();
      test_reset_mid_slot();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
